// File: rtl/kpyd_scan_debounce_if.sv
// Key event bus between the keypad scanner and its consumer.
// master = scanner (event source), slave = consumer.
interface kpyd_scan_debounce_if #(
    parameter int unsigned code_width = 4
);
    logic                  key_v;
    logic                  key_ready;
    logic [code_width-1:0] key_code;
    logic                  key_held;
    logic                  multi;
    logic                  overrun;

    modport master (
        output key_v, key_code, key_held, multi, overrun,
        input  key_ready
    );

    modport slave (
        input  key_v, key_code, key_held, multi, overrun,
        output key_ready
    );
endinterface

// File: rtl/kpyd_scan_debounce.sv
// Matrix keypad scanner: one-cold column strobes, synchronised active-low rows,
// frame-based debounce and one encoded event per press on a valid/ready bus.
module kpyd_scan_debounce #(
    parameter int unsigned rows_p            = 4,
    parameter int unsigned cols_p            = 4,
    parameter int unsigned settle_cycles_p   = 1200,
    parameter int unsigned debounce_frames_p = 4
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [rows_p-1:0] kpyd_row_i,
    output logic [cols_p-1:0] kpyd_col_o,
    kpyd_scan_debounce_if.master key_bus
);
    localparam int unsigned code_width_lp = $clog2(rows_p * cols_p);
    localparam int unsigned col_w_lp      = $clog2(cols_p);
    localparam int unsigned settle_w_lp   = $clog2(settle_cycles_p);
    localparam int unsigned cnt_w_lp      = $clog2(debounce_frames_p + 1);

    typedef enum logic [1:0] {ST_SETTLE, ST_SAMPLE, ST_EVAL} state_e;

    state_e                   state_q, state_d;
    logic [settle_w_lp-1:0]   settle_q, settle_d;
    logic [col_w_lp-1:0]      col_q;
    logic [cols_p-1:0]        col_oh_q;
    logic [rows_p-1:0]        row_meta_q, row_sync_q;
    logic [rows_p-1:0]        frame_q [cols_p];

    logic [code_width_lp-1:0] cand_code_q;
    logic [cnt_w_lp-1:0]      cand_cnt_q, rel_cnt_q;
    logic                     reported_q;
    logic                     key_v_q, key_held_q, multi_q, overrun_q;
    logic [code_width_lp-1:0] key_code_q;

    logic                     single, many;
    logic [code_width_lp-1:0] scan_code;
    logic [cnt_w_lp-1:0]      cand_inc, rel_inc, cand_next;
    logic                     new_evt, release_done;

    // Scan state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Scan next-state: settle_cycles_p-1 settle cycles, one sample, EVAL after last column
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            ST_SETTLE: begin
                if (settle_q == settle_w_lp'(settle_cycles_p - 2)) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_SAMPLE: state_d = (col_q == col_w_lp'(cols_p - 1)) ? ST_EVAL : ST_SETTLE;
            ST_EVAL:   state_d = ST_SETTLE;
            default:   state_d = ST_SETTLE;
        endcase
    end

    // Frame classification: none / exactly one (with its code) / more than one
    always_comb begin
        single    = 1'b0;
        many      = 1'b0;
        scan_code = '0;
        for (int c = 0; c < cols_p; c++) begin
            for (int r = 0; r < rows_p; r++) begin
                if (frame_q[c][r]) begin
                    if (single || many) begin
                        many   = 1'b1;
                        single = 1'b0;
                    end else begin
                        single    = 1'b1;
                        scan_code = code_width_lp'(r * cols_p + c);
                    end
                end
            end
        end
    end

    assign cand_inc  = (cand_cnt_q == cnt_w_lp'(debounce_frames_p)) ? cand_cnt_q : cand_cnt_q + 1'b1;
    assign rel_inc   = (rel_cnt_q  == cnt_w_lp'(debounce_frames_p)) ? rel_cnt_q  : rel_cnt_q  + 1'b1;
    assign cand_next = ((cand_cnt_q != '0) && (scan_code == cand_code_q)) ? cand_inc : cnt_w_lp'(1);
    assign new_evt      = single && (cand_next == cnt_w_lp'(debounce_frames_p)) && !reported_q;
    assign release_done = (rel_inc == cnt_w_lp'(debounce_frames_p));

    // Row sampling, column drive, debounce and event handshake
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            col_q       <= '0;
            col_oh_q    <= {{(cols_p-1){1'b1}}, 1'b0};
            for (int c = 0; c < cols_p; c++) frame_q[c] <= '0;
            cand_code_q <= '0;
            cand_cnt_q  <= '0;
            rel_cnt_q   <= '0;
            reported_q  <= 1'b0;
            key_v_q     <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            multi_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            row_meta_q <= kpyd_row_i;
            row_sync_q <= row_meta_q;
            multi_q    <= 1'b0;
            overrun_q  <= 1'b0;
            if (key_v_q && key_bus.key_ready) key_v_q <= 1'b0;

            if (state_q == ST_SAMPLE) begin
                frame_q[col_q] <= ~row_sync_q;
                col_q          <= (col_q == col_w_lp'(cols_p - 1)) ? '0 : col_q + 1'b1;
                col_oh_q       <= {col_oh_q[cols_p-2:0], col_oh_q[cols_p-1]};
            end

            if (state_q == ST_EVAL) begin
                if (many) begin
                    multi_q    <= 1'b1;
                    cand_cnt_q <= '0;
                end else if (single) begin
                    cand_code_q <= scan_code;
                    cand_cnt_q  <= cand_next;
                    rel_cnt_q   <= '0;
                    if (new_evt) begin
                        key_held_q <= 1'b1;
                        reported_q <= 1'b1;
                        // An unaccepted event is kept; the new one is dropped
                        if (key_v_q && !key_bus.key_ready) begin
                            overrun_q <= 1'b1;
                        end else begin
                            key_v_q    <= 1'b1;
                            key_code_q <= scan_code;
                        end
                    end
                end else begin
                    rel_cnt_q  <= rel_inc;
                    cand_cnt_q <= '0;
                    if (release_done) begin
                        key_held_q <= 1'b0;
                        reported_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign kpyd_col_o       = col_oh_q;
    assign key_bus.key_v    = key_v_q;
    assign key_bus.key_code = key_code_q;
    assign key_bus.key_held = key_held_q;
    assign key_bus.multi    = multi_q;
    assign key_bus.overrun  = overrun_q;

endmodule
